// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared types and constants for the sequential parity checker
package parity_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } frame_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_checker_seq_if.sv
// rtl/parity_checker_seq_if.sv - beat input, control and status bundle of the parity checker
interface parity_checker_seq_if #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_parity;
    logic              in_last;
    logic              odd_mode;
    logic              clr;
    logic              out_valid;
    logic              err;
    logic              err_sticky;
    logic [CNT_W-1:0]  err_cnt;
    logic              frame_err;

    modport master (
        output in_valid, in_data, in_parity, in_last, odd_mode, clr,
        input  out_valid, err, err_sticky, err_cnt, frame_err
    );

    modport slave (
        input  in_valid, in_data, in_parity, in_last, odd_mode, clr,
        output out_valid, err, err_sticky, err_cnt, frame_err
    );
endinterface

// File: rtl/parity_calc.sv
// rtl/parity_calc.sv - combinational per-beat parity mismatch detector
module parity_calc
    import parity_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic              parity_i,
    input  logic              odd_mode_i,
    output logic              bad_o
);
    logic ones_odd;

    assign ones_odd = ^{data_i, parity_i};
    // Odd mode expects an odd total weight, even mode an even one.
    assign bad_o    = (odd_mode_i == PAR_ODD) ? ~ones_odd : ones_odd;

endmodule

// File: rtl/parity_checker_seq.sv
// rtl/parity_checker_seq.sv - registered parity checker with sticky/saturating error status
// Optional frame longitudinal-parity check compiled in with PARITY_CHK_FRAME_EN.
module parity_checker_seq
    import parity_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    parity_checker_seq_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             bad;
    logic             out_valid_q, out_valid_d;
    logic             err_q, err_d;
    logic             err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             frame_err_q, frame_err_d;

    parity_calc #(.DATA_W(DATA_W)) u_calc (
        .data_i     (bus.in_data),
        .parity_i   (bus.in_parity),
        .odd_mode_i (bus.odd_mode),
        .bad_o      (bad)
    );

    always_comb begin
        out_valid_d  = bus.in_valid;
        err_d        = bus.in_valid & bad;
        err_sticky_d = err_sticky_q | err_d;
        err_cnt_d    = err_cnt_q;
        if (err_d && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
        // Clear beats the beat's own error into the status, but err itself still reports.
        if (bus.clr) begin
            err_sticky_d = 1'b0;
            err_cnt_d    = '0;
        end
    end

`ifdef PARITY_CHK_FRAME_EN
    frame_state_e      state_q, state_d;
    logic [DATA_W-1:0] xor_q, xor_d;

    always_comb begin
        state_d     = state_q;
        xor_d       = xor_q;
        frame_err_d = 1'b0;
        if (bus.in_valid) begin
            case (state_q)
                IDLE: begin
                    if (!bus.in_last) begin
                        state_d = IN_FRAME;
                        xor_d   = bus.in_data;
                    end
                end
                IN_FRAME: begin
                    if (bus.in_last) begin
                        frame_err_d = (bus.in_data != xor_q);
                        xor_d       = '0;
                        state_d     = IDLE;
                    end else begin
                        xor_d = xor_q ^ bus.in_data;
                    end
                end
            endcase
        end
        if (bus.clr) begin
            state_d = IDLE;
            xor_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            xor_q   <= '0;
        end else begin
            state_q <= state_d;
            xor_q   <= xor_d;
        end
    end
`else
    assign frame_err_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.err        = err_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_parity_checker_seq.sv
// tb/tb_parity_checker_seq.sv - randomized self-checking bench for parity_checker_seq (8- and 2-bit counters)
module tb_parity_checker_seq;
    import parity_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic       v = 1'b0, p = 1'b0, l = 1'b0, om = 1'b0, cl = 1'b0;
    logic [3:0] d = '0;

    int checks = 0;
    int errors = 0;

    logic       exp_ov, exp_err, exp_sticky, exp_fe;
    logic [7:0] exp_cnt8;
    logic [1:0] exp_cnt2;
`ifdef PARITY_CHK_FRAME_EN
    logic [3:0] fq[$];
`endif

    parity_checker_seq_if #(.DATA_W(4), .CNT_W(8)) if8 ();
    parity_checker_seq_if #(.DATA_W(4), .CNT_W(2)) if2 ();

    assign if8.in_valid = v;  assign if2.in_valid = v;
    assign if8.in_data  = d;  assign if2.in_data  = d;
    assign if8.in_parity = p; assign if2.in_parity = p;
    assign if8.in_last  = l;  assign if2.in_last  = l;
    assign if8.odd_mode = om; assign if2.odd_mode = om;
    assign if8.clr      = cl; assign if2.clr      = cl;

    parity_checker_seq #(.DATA_W(4), .CNT_W(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    parity_checker_seq #(.DATA_W(4), .CNT_W(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    always #5 clk = ~clk;

    function automatic logic [11:0] obs8();
        return {if8.out_valid, if8.err, if8.err_sticky, if8.err_cnt, if8.frame_err};
    endfunction

    function automatic logic [11:0] exp8();
        return {exp_ov, exp_err, exp_sticky, exp_cnt8, exp_fe};
    endfunction

    task automatic model_reset();
        exp_ov = 0; exp_err = 0; exp_sticky = 0; exp_fe = 0;
        exp_cnt8 = 0; exp_cnt2 = 0;
`ifdef PARITY_CHK_FRAME_EN
        fq.delete();
`endif
    endtask

    // Drive one cycle, advance the reference, and return 1 time unit after the edge.
    task automatic step(input logic vv, input logic [3:0] dd, input logic pp,
                        input logic ll, input logic oo, input logic cc);
        logic [3:0] acc;
        @(negedge clk);
        v = vv; d = dd; p = pp; l = ll; om = oo; cl = cc;
        exp_ov  = vv;
        exp_err = vv && (($countones({dd, pp}) % 2) != int'(oo));
        if (cc) begin
            exp_cnt8 = 0; exp_cnt2 = 0; exp_sticky = 0;
        end else if (exp_err) begin
            exp_sticky = 1;
            if (exp_cnt8 != 8'd255) exp_cnt8 = exp_cnt8 + 1;
            if (exp_cnt2 != 2'd3)   exp_cnt2 = exp_cnt2 + 1;
        end
        exp_fe = 0;
        acc = '0;
`ifdef PARITY_CHK_FRAME_EN
        if (vv) begin
            if (ll) begin
                if (fq.size() != 0) begin
                    foreach (fq[k]) acc ^= fq[k];
                    exp_fe = (dd != acc);
                end
                fq.delete();
            end else begin
                fq.push_back(dd);
            end
        end
        if (cc) fq.delete();
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #3;
        checks++;
        if (obs8() !== 12'h0 || if2.err_cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %h cnt2=%0d, want 000 cnt2=0", obs8(), if2.err_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, PAR_EVEN, 0);
        checks++;
        if (obs8() !== 12'h0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h want 000", obs8());
        end
    endtask

    task automatic test_exhaustive();
        logic [4:0] w;
        for (int i = 0; i < 32; i++) begin
            w = 5'(i);
            step(1, w[4:1], w[0], 0, PAR_EVEN, 0);
            checks++;
            if (obs8() !== exp8()) begin
                errors++;
                $display("FAIL exhaustive[%0d]: got %h want %h", i, obs8(), exp8());
            end
        end
        checks++;
        if (if8.err_cnt !== 8'd16 || if8.err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL exhaustive_total: cnt=%0d sticky=%b, want cnt=16 sticky=1", if8.err_cnt, if8.err_sticky);
        end
    endtask

    task automatic test_odd_mode();
        step(0, 0, 0, 0, PAR_EVEN, 1);
        step(1, 4'b0000, 0, 0, PAR_ODD, 0);
        checks++;
        if (if8.err !== 1'b1 || if8.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL odd_p0: err=%b ov=%b want err=1 ov=1", if8.err, if8.out_valid);
        end
        step(1, 4'b0000, 1, 0, PAR_ODD, 0);
        checks++;
        if (if8.err !== 1'b0) begin
            errors++;
            $display("FAIL odd_p1: err=%b want 0", if8.err);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] tbl[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        step(0, 0, 0, 0, PAR_EVEN, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 4'h1, 0, 0, PAR_EVEN, 0);
            checks++;
            if (if2.err_cnt !== tbl[i] || if2.err !== 1'b1) begin
                errors++;
                $display("FAIL sat_cnt[%0d]: cnt=%0d err=%b want cnt=%0d err=1", i, if2.err_cnt, if2.err, tbl[i]);
            end
        end
        step(1, 4'h1, 0, 0, PAR_EVEN, 1);
        checks++;
        if (if2.err_cnt !== 2'd0 || if2.err !== 1'b1 || if2.err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL clr_wins: cnt=%0d err=%b sticky=%b want 0 1 0", if2.err_cnt, if2.err, if2.err_sticky);
        end
    endtask

    task automatic test_frame();
        logic want;
        step(0, 0, 0, 0, PAR_EVEN, 1);
        step(1, 4'h3, ^4'h3, 0, PAR_EVEN, 0);
        step(1, 4'h5, ^4'h5, 0, PAR_EVEN, 0);
        step(1, 4'h6, ^4'h6, 1, PAR_EVEN, 0);
        checks++;
        if (if8.frame_err !== 1'b0 || if8.err !== 1'b0 || obs8() !== exp8()) begin
            errors++;
            $display("FAIL frame_good: fe=%b err=%b got %h want %h", if8.frame_err, if8.err, obs8(), exp8());
        end
`ifdef PARITY_CHK_FRAME_EN
        want = 1'b1;
`else
        want = 1'b0;
`endif
        step(1, 4'h3, ^4'h3, 0, PAR_EVEN, 0);
        step(1, 4'h5, ^4'h5, 0, PAR_EVEN, 0);
        step(1, 4'h7, ~^4'h7, 1, PAR_EVEN, 0);
        checks++;
        if (if8.frame_err !== want || if8.err !== 1'b1 || obs8() !== exp8()) begin
            errors++;
            $display("FAIL frame_bad: fe=%b err=%b want fe=%b err=1", if8.frame_err, if8.err, want);
        end
        step(0, 0, 0, 0, PAR_EVEN, 0);
        checks++;
        if (if8.frame_err !== 1'b0 || if8.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_one_cycle: fe=%b ov=%b want 0 0", if8.frame_err, if8.out_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        step(1, 4'hF, 0, 0, PAR_EVEN, 0);
        step(1, 4'h1, 0, 0, PAR_EVEN, 0);
        @(negedge clk);
        v = 0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs8() !== 12'h0 || if2.err_cnt !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: got %h cnt2=%0d want 000 0", obs8(), if2.err_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 4'h1, 1, 0, PAR_EVEN, 0);
        step(1, 4'h1, 1, 1, PAR_EVEN, 0);
        checks++;
        if (if8.frame_err !== 1'b0 || obs8() !== exp8()) begin
            errors++;
            $display("FAIL post_reset_frame: got %h want %h", obs8(), exp8());
        end
    endtask

    task automatic test_gaps();
        logic [3:0] x, dd;
        for (int f = 0; f < 4; f++) begin
            x = '0;
            for (int b = 0; b < 4; b++) begin
                dd = 4'($urandom);
                if (b == 3) dd = (f % 2 == 0) ? x : ~x;
                x ^= dd;
                step(1, dd, ^dd, (b == 3), PAR_EVEN, 0);
                checks++;
                if (obs8() !== exp8()) begin
                    errors++;
                    $display("FAIL gap_beat f%0d b%0d: got %h want %h", f, b, obs8(), exp8());
                end
                if (b != 3) begin
                    for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                        step(0, 4'($urandom), $urandom, $urandom, PAR_EVEN, 0);
                        checks++;
                        if (if8.out_valid !== 1'b0 || if8.err !== 1'b0 || if8.frame_err !== 1'b0 || obs8() !== exp8()) begin
                            errors++;
                            $display("FAIL gap_idle f%0d b%0d: got %h want %h", f, b, obs8(), exp8());
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 4'($urandom), $urandom, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0 ? ~om : om, $urandom_range(0, 40) == 0);
            checks++;
            if (obs8() !== exp8() || if2.err_cnt !== exp_cnt2 || if2.err_sticky !== exp_sticky) begin
                errors++;
                $display("FAIL random[%0d]: got %h cnt2=%0d want %h cnt2=%0d", i, obs8(), if2.err_cnt, exp8(), exp_cnt2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_exhaustive();
        test_odd_mode();
        test_saturate();
        test_frame();
        test_reset_mid_frame();
        test_gaps();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
